// File: rtl/spi_target.sv
// ============================================================================
// Module   : spi_target
// Brief    : SPI mode-0 target bridging 16-bit frames onto a simple register bus
// Revision : 1.0
// ============================================================================
`default_nettype none

module spi_target #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       s_en,
    input  logic       s_clk,
    input  logic       mosi,
    output logic       miso,
    output logic [6:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_re,
    input  logic [7:0] reg_rdata,
    output logic       frame_err
);

    localparam int MSB = SYNC_STAGES - 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [MSB:0] r_en_sync;
    logic [MSB:0] r_sclk_sync;
    logic [MSB:0] r_mosi_sync;
    logic [MSB:0] r_warm;
    logic         r_armed;
    logic         r_en_d;
    logic         r_sclk_d;
    logic [3:0]   r_cnt;
    logic [6:0]   r_rx;
    logic [7:0]   r_tx;
    logic         r_wr;
    logic         r_re_d;

    logic       w_en;
    logic       w_sclk;
    logic       w_mosi;
    logic       w_en_rise;
    logic       w_en_fall;
    logic       w_sclk_rise;
    logic       w_sclk_fall;
    logic       w_sample;
    logic       w_cmd_last;
    logic       w_last;
    logic       w_abort;
    logic [7:0] w_rx_next;

    assign w_en        = r_en_sync[MSB];
    assign w_sclk      = r_sclk_sync[MSB];
    assign w_mosi      = r_mosi_sync[MSB];
    assign w_en_rise   = w_en & ~r_en_d;
    assign w_en_fall   = ~w_en & r_en_d;
    assign w_sclk_rise = w_sclk & ~r_sclk_d;
    assign w_sclk_fall = ~w_sclk & r_sclk_d;
    assign w_sample    = w_sclk_rise && (r_state == ST_CMD || r_state == ST_DATA);
    assign w_cmd_last  = w_sample && (r_state == ST_CMD) && (r_cnt == 4'd7);
    assign w_last      = w_sample && (r_state == ST_DATA) && (r_cnt == 4'd15);
    assign w_rx_next   = {r_rx, w_mosi};
    assign miso        = (r_state == ST_DATA && !r_wr) ? r_tx[7] : 1'b0;

    // r_warm marks when the synchronizers hold real post-reset samples; a frame
    // may only start once s_en has been seen low after that point.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_en_sync   <= '0;
            r_sclk_sync <= '0;
            r_mosi_sync <= '0;
            r_warm      <= '0;
            r_armed     <= 1'b0;
            r_en_d      <= 1'b0;
            r_sclk_d    <= 1'b0;
        end else begin
            r_en_sync   <= {r_en_sync[SYNC_STAGES-2:0], s_en};
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], s_clk};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
            r_warm      <= {r_warm[SYNC_STAGES-2:0], 1'b1};
            r_armed     <= r_armed | (r_warm[MSB] & ~w_en);
            r_en_d      <= w_en;
            r_sclk_d    <= w_sclk;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        w_abort = 1'b0;
        case (r_state)
            ST_IDLE: if (r_armed && w_en_rise) w_next = ST_CMD;
            ST_CMD: begin
                if (w_en_fall) begin
                    w_next  = ST_IDLE;
                    w_abort = 1'b1;
                end else if (w_cmd_last) begin
                    w_next = ST_DATA;
                end
            end
            ST_DATA: begin
                // Completion beats a simultaneous s_en fall.
                if (w_last) begin
                    w_next = w_en_fall ? ST_IDLE : ST_DONE;
                end else if (w_en_fall) begin
                    w_next  = ST_IDLE;
                    w_abort = 1'b1;
                end
            end
            ST_DONE: if (w_en_fall) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_rx      <= '0;
            r_tx      <= '0;
            r_wr      <= 1'b0;
            r_re_d    <= 1'b0;
            reg_addr  <= '0;
            reg_wdata <= '0;
            reg_we    <= 1'b0;
            reg_re    <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            reg_we    <= 1'b0;
            reg_re    <= 1'b0;
            frame_err <= w_abort;
            r_re_d    <= reg_re;
            if (r_state == ST_IDLE && w_next == ST_CMD) begin
                r_cnt <= '0;
                r_rx  <= '0;
                r_tx  <= '0;
                r_wr  <= 1'b0;
            end
            if (w_sample && !w_abort) begin
                r_rx <= w_rx_next[6:0];
                if (r_cnt != 4'd15) r_cnt <= r_cnt + 4'd1;
            end
            if (w_cmd_last && !w_abort) begin
                reg_addr <= w_rx_next[6:0];
                r_wr     <= w_rx_next[7];
                reg_re   <= ~w_rx_next[7];
            end
            if (w_last && r_wr) begin
                reg_we    <= 1'b1;
                reg_wdata <= w_rx_next;
            end
            // The fall right after the 8th rise keeps bit 7 on the line.
            if (w_sclk_fall && r_state == ST_DATA && r_cnt != 4'd8)
                r_tx <= {r_tx[6:0], 1'b0};
            if (r_re_d)
                r_tx <= reg_rdata;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_spi_target.sv
// ============================================================================
// Module   : tb_spi_target
// Brief    : Directed self-checking bench for spi_target
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_spi_target;

    localparam int SYNC = 3;
    localparam int PH   = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       s_en = 1'b0;
    logic       s_clk = 1'b0;
    logic       mosi = 1'b0;
    logic       miso;
    logic [6:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_re;
    logic [7:0] reg_rdata = 8'h00;
    logic       frame_err;

    always #5 clk = ~clk;

    spi_target #(.SYNC_STAGES(SYNC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_en      (s_en),
        .s_clk     (s_clk),
        .mosi      (mosi),
        .miso      (miso),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_we    (reg_we),
        .reg_re    (reg_re),
        .reg_rdata (reg_rdata),
        .frame_err (frame_err)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int n_we   = 0;
    int n_re   = 0;
    int n_err  = 0;

    logic [7:0] rf       [128];
    bit         rf_wr    [128] = '{default: 1'b0};
    logic [7:0] model_mem[128];
    bit         model_wr [128] = '{default: 1'b0};

    logic [6:0] exp_addr = '0;
    logic [7:0] exp_wdata = '0;
    bit         miso0_req = 1'b1;
    logic [6:0] last_we_addr = '0;
    logic [7:0] last_we_data = '0;
    logic [7:0] miso_cap = '0;

    function automatic logic [7:0] dflt(input logic [6:0] a);
        return {1'b0, a} ^ 8'h66;
    endfunction

    function automatic logic [7:0] model_rd(input logic [6:0] a);
        return model_wr[a] ? model_mem[a] : dflt(a);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Register-file responder: read data appears one clk after reg_re.
    always @(posedge clk) begin
        if (reg_re) reg_rdata <= rf_wr[reg_addr] ? rf[reg_addr] : dflt(reg_addr);
        if (reg_we) begin
            rf[reg_addr]    <= reg_wdata;
            rf_wr[reg_addr] <= 1'b1;
        end
    end

    // Per-cycle compare against the current frame's expectations.
    always @(negedge clk) begin
        chk("we_re_exclusive", {31'b0, reg_we & reg_re}, 32'd0);
        if (miso0_req) chk("miso_zero", {31'b0, miso}, 32'd0);
        if (reg_we) begin
            n_we++;
            chk("we_addr", {25'b0, reg_addr}, {25'b0, exp_addr});
            chk("we_data", {24'b0, reg_wdata}, {24'b0, exp_wdata});
            last_we_addr = reg_addr;
            last_we_data = reg_wdata;
        end
        if (reg_re) begin
            n_re++;
            chk("re_addr", {25'b0, reg_addr}, {25'b0, exp_addr});
        end
        if (frame_err) n_err++;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clk_bits(input logic [15:0] w, input int n, input bit drop16);
        for (int i = 0; i < n; i++) begin
            mosi = (i < 16) ? w[15-i] : 1'b0;
            cyc(PH);
            if (i >= 8 && i < 16) miso_cap[15-i] = miso;
            else chk("miso_outside_data", {31'b0, miso}, 32'd0);
            s_clk = 1'b1;
            if (drop16 && i == 15) s_en = 1'b0;
            cyc(PH);
            s_clk = 1'b0;
        end
    endtask

    task automatic run_frame(input string tag, input logic [15:0] w, input int n, input bit drop16);
        int  we0  = n_we;
        int  re0  = n_re;
        int  err0 = n_err;
        bit  wr   = w[15];
        bit  full = (n >= 16);
        exp_addr  = w[14:8];
        exp_wdata = w[7:0];
        miso0_req = wr;
        miso_cap  = '0;
        s_en = 1'b1;
        cyc(PH);
        clk_bits(w, n, drop16);
        cyc(PH);
        s_en = 1'b0;
        cyc(3 * PH + SYNC);
        miso0_req = 1'b1;
        chk({tag, "_we_count"}, n_we - we0, (wr && full) ? 32'd1 : 32'd0);
        chk({tag, "_re_count"}, n_re - re0, (!wr && n >= 8) ? 32'd1 : 32'd0);
        chk({tag, "_err_count"}, n_err - err0, full ? 32'd0 : 32'd1);
        if (!wr && full) chk({tag, "_miso_bits"}, {24'b0, miso_cap}, {24'b0, model_rd(w[14:8])});
        if (wr && full) begin
            model_mem[w[14:8]] = w[7:0];
            model_wr[w[14:8]]  = 1'b1;
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_miso"}, {31'b0, miso}, 32'd0);
        chk({tag, "_addr"}, {25'b0, reg_addr}, 32'd0);
        chk({tag, "_wdata"}, {24'b0, reg_wdata}, 32'd0);
        chk({tag, "_we"}, {31'b0, reg_we}, 32'd0);
        chk({tag, "_re"}, {31'b0, reg_re}, 32'd0);
        chk({tag, "_err"}, {31'b0, frame_err}, 32'd0);
    endtask

    initial begin
        int we0, re0, err0;
        cyc(3);
        chk_outputs_zero("reset");
        rst_n = 1'b1;
        cyc(8);

        run_frame("wr_12", 16'h92A5, 16, 1'b0);
        chk("wr_12_literal_addr", {25'b0, last_we_addr}, 32'h12);
        chk("wr_12_literal_data", {24'b0, last_we_data}, 32'hA5);

        run_frame("rd_3c", 16'h3C00, 16, 1'b0);
        chk("rd_3c_literal_bits", {24'b0, miso_cap}, 32'h5A);

        run_frame("wr_3c", 16'hBC81, 16, 1'b0);
        run_frame("rd_3c_again", 16'h3C00, 16, 1'b0);
        chk("rd_3c_again_literal", {24'b0, miso_cap}, 32'h81);

        run_frame("abort_wr", 16'h8F77, 11, 1'b0);
        run_frame("after_abort", 16'h8F77, 16, 1'b0);
        run_frame("extra_edges", 16'hA0C3, 20, 1'b0);
        chk("extra_edges_literal_data", {24'b0, last_we_data}, 32'hC3);
        run_frame("drop_at_16", 16'hB11E, 16, 1'b1);
        run_frame("abort_rd", 16'h1200, 10, 1'b0);
        run_frame("rd_12", 16'h1200, 16, 1'b0);

        // Reset in the middle of a frame with s_en held high across release.
        we0 = n_we; re0 = n_re; err0 = n_err;
        exp_addr = 7'h55; exp_wdata = 8'h3C;
        s_en = 1'b1;
        cyc(PH);
        clk_bits(16'hD53C, 5, 1'b0);
        rst_n = 1'b0;
        cyc(2);
        chk_outputs_zero("midframe_reset");
        rst_n = 1'b1;
        cyc(PH);
        clk_bits(16'hD53C, 16, 1'b0);
        cyc(PH);
        chk("stale_en_we", n_we - we0, 32'd0);
        chk("stale_en_re", n_re - re0, 32'd0);
        chk("stale_en_err", n_err - err0, 32'd0);
        s_en = 1'b0;
        cyc(3 * PH + SYNC);
        run_frame("post_reset", 16'hD53C, 16, 1'b0);
        run_frame("rd_55", 16'h5500, 16, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
